// File: rtl/bcd_pkg.sv
// Shared definitions for the serial packed-BCD adder sequencer:
// digit geometry, controller state encoding and a digit validity helper.
package bcd_pkg;

  localparam int BCD_DIGIT_W = 4;
  localparam logic [BCD_DIGIT_W-1:0] BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // A nibble is a legal BCD digit only in the range 0..9.
  function automatic logic digit_invalid(input logic [BCD_DIGIT_W-1:0] d);
    return (d > BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_serial_add_ctrl_if.sv
// Bundle of the operand-source handshake and the shared digit-adder link.
// The controller connects through the slave modport; whoever drives the
// operands and models the digit adder connects through the master modport.
interface bcd_serial_add_ctrl_if #(
  parameter int DIGITS = 4
);

  logic                  start;
  logic [4*DIGITS-1:0]   a_in;
  logic [4*DIGITS-1:0]   b_in;
  logic                  cin;
  logic                  ready;
  logic                  busy;
  logic                  done;
  logic                  err;
  logic [4*DIGITS-1:0]   sum_out;
  logic                  cout;
  logic [3:0]            add_a;
  logic [3:0]            add_b;
  logic                  add_cin;
  logic [3:0]            add_sum;
  logic                  add_cout;

  modport slave (
    input  start, a_in, b_in, cin, add_sum, add_cout,
    output ready, busy, done, err, sum_out, cout, add_a, add_b, add_cin
  );

  modport master (
    output start, a_in, b_in, cin, add_sum, add_cout,
    input  ready, busy, done, err, sum_out, cout, add_a, add_b, add_cin
  );

endinterface

// File: rtl/bcd_digit_check.sv
// Flags a packed-BCD vector that contains any nibble above 9.
module bcd_digit_check
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic [BCD_DIGIT_W*DIGITS-1:0] digits,
  output logic                          any_invalid
);

  // OR together the per-digit range violations.
  always_comb begin
    any_invalid = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      any_invalid = any_invalid | digit_invalid(digits[BCD_DIGIT_W*i +: BCD_DIGIT_W]);
    end
  end

endmodule

// File: rtl/bcd_serial_add_ctrl.sv
// Serial packed-BCD adder sequencer. One external single-digit BCD adder is
// reused once per clock, least significant digit first; the decimal carry
// ripples through carry_r between digits. Operands with a non-BCD nibble are
// rejected at acceptance and reported through err with a zero result.
module bcd_serial_add_ctrl
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  bcd_serial_add_ctrl_if.slave  bus
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  state_t                               state_r;
  state_t                               state_s;
  logic [DIGITS-1:0][BCD_DIGIT_W-1:0]   a_r;
  logic [DIGITS-1:0][BCD_DIGIT_W-1:0]   b_r;
  logic [DIGITS-1:0][BCD_DIGIT_W-1:0]   sum_r;
  logic                                 carry_r;
  logic                                 cout_r;
  logic                                 err_r;
  logic [IDX_W-1:0]                     idx_r;
  logic                                 a_bad_s;
  logic                                 b_bad_s;
  logic [BCD_DIGIT_W-1:0]               dig_a_s;
  logic [BCD_DIGIT_W-1:0]               dig_b_s;

  bcd_digit_check #(.DIGITS(DIGITS)) u_chk_a (
    .digits      (bus.a_in),
    .any_invalid (a_bad_s)
  );

  bcd_digit_check #(.DIGITS(DIGITS)) u_chk_b (
    .digits      (bus.b_in),
    .any_invalid (b_bad_s)
  );

  // Controller state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic: bad operands skip straight to DONE with err set.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.start) begin
          if (a_bad_s || b_bad_s) begin
            state_s = ST_DONE;
          end else begin
            state_s = ST_RUN;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (idx_r == LAST_IDX) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // Operand capture, per-digit result write-back and carry ripple.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r     <= '0;
      b_r     <= '0;
      sum_r   <= '0;
      carry_r <= 1'b0;
      cout_r  <= 1'b0;
      err_r   <= 1'b0;
      idx_r   <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.start) begin
            a_r     <= bus.a_in;
            b_r     <= bus.b_in;
            carry_r <= bus.cin;
            sum_r   <= '0;
            cout_r  <= 1'b0;
            err_r   <= a_bad_s | b_bad_s;
            idx_r   <= '0;
          end
        end
        ST_RUN: begin
          for (int i = 0; i < DIGITS; i++) begin
            if (idx_r == i[IDX_W-1:0]) begin
              sum_r[i] <= bus.add_sum;
            end
          end
          carry_r <= bus.add_cout;
          if (idx_r == LAST_IDX) begin
            cout_r <= bus.add_cout;
          end else begin
            idx_r <= idx_r + IDX_W'(1);
          end
        end
        default: begin
          // DONE holds every result register for the requester.
        end
      endcase
    end
  end

  // Select the current digit pair out of the operand registers.
  always_comb begin
    dig_a_s = 4'd0;
    dig_b_s = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_r == i[IDX_W-1:0]) begin
        dig_a_s = a_r[i];
        dig_b_s = b_r[i];
      end else begin
        dig_a_s = dig_a_s;
        dig_b_s = dig_b_s;
      end
    end
  end

  // The shared adder only sees live operands while a sum is in progress.
  assign bus.add_a   = (state_r == ST_RUN) ? dig_a_s : 4'd0;
  assign bus.add_b   = (state_r == ST_RUN) ? dig_b_s : 4'd0;
  assign bus.add_cin = (state_r == ST_RUN) ? carry_r : 1'b0;

  assign bus.ready   = (state_r == ST_IDLE);
  assign bus.busy    = (state_r == ST_RUN);
  assign bus.done    = (state_r == ST_DONE);
  assign bus.err     = err_r;
  assign bus.sum_out = sum_r;
  assign bus.cout    = cout_r;

endmodule
